// File: rtl/aes256_encrypt_iter_pkg.sv
// Shared AES-256 encryption definitions: round/column counts, the state width,
// the GF(2^8) reduction constant, FSM encodings, the forward S-box table and
// the xtime helper.
package aes256_encrypt_iter_pkg;

  localparam int         AES_NR  = 14;
  localparam int         AES_NB  = 4;
  localparam int         STATE_W = 128;
  localparam logic [7:0] GF_RED  = 8'h1B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_e;

  // Ascending outer range: element k is the k-th entry in the listing below.
  localparam logic [0:255][7:0] SBOX_TBL = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped when last_i) and AddRoundKey.
// Ports: state_in_i  - round input state, byte k at bits [127-8k -: 8]
//        round_key_i - round key, same byte order
//        last_i      - final round, MixColumns bypassed
//        state_out_o - round result
module aes_enc_round
  import aes256_encrypt_iter_pkg::*;
(
  input  logic [127:0] state_in_i,
  input  logic [127:0] round_key_i,
  input  logic         last_i,
  output logic [127:0] state_out_o
);

  // Ascending byte index so element k is byte k (MSB-first on the bus).
  logic [0:15][7:0] in_b, sb, sr, mc;

  assign in_b = state_in_i;

  for (genvar k = 0; k < 16; k++) begin : g_sub
    assign sb[k] = sbox(in_b[k]);
  end

  for (genvar c = 0; c < AES_NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r rotates left by r columns.
      assign sr[4*c+r] = sb[4*((c+r)%AES_NB)+r];
      // 2*a_r ^ 3*a_{r+1} ^ a_{r+2} ^ a_{r+3}, with 3*x folded as xtime(x)^x.
      assign mc[4*c+r] = xtime(sr[4*c+r] ^ sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                       ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
    end
  end

  assign state_out_o = (last_i ? sr : mc) ^ round_key_i;

endmodule

// File: rtl/aes256_encrypt_iter.sv
// Iterative AES-256 encryption core: initial AddRoundKey on START, then one
// round per clock against an external round-key table addressed by round_idx_o.
// Ports: clk_i, rst_i (sync, active high), start_i, plaintext_i,
//        round_idx_o (key index needed this cycle), round_key_i,
//        busy_o, done_o (1-cycle pulse), ciphertext_o (held until next done).
module aes256_encrypt_iter
  import aes256_encrypt_iter_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] plaintext_i,
  output logic [3:0]   round_idx_o,
  input  logic [127:0] round_key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] ciphertext_o
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  fsm_e                 fsm_q, fsm_d;
  logic [3:0]           round_q, round_d;
  logic [STATE_W-1:0]   state_q, state_d;
  logic [STATE_W-1:0]   ct_q, ct_d;
  logic                 done_q, done_d;
  logic [STATE_W-1:0]   rnd_out;

  aes_enc_round u_round (
    .state_in_i  (state_q),
    .round_key_i (round_key_i),
    .last_i      (round_q == LAST_RND),
    .state_out_o (rnd_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= ST_IDLE;
      round_q <= '0;
      state_q <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        // round_idx_o is 0 here, so round_key_i is key 0.
        if (start_i) begin
          state_d = plaintext_i ^ round_key_i;
          round_d = 4'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (round_q == LAST_RND) begin
          ct_d    = rnd_out;
          done_d  = 1'b1;
          round_d = '0;
          fsm_d   = ST_IDLE;
        end else begin
          state_d = rnd_out;
          round_d = round_q + 4'd1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (fsm_q == ST_RUN);
    round_idx_o = (fsm_q == ST_RUN) ? round_q : 4'd0;
  end

  assign done_o       = done_q;
  assign ciphertext_o = ct_q;

endmodule

// File: tb/tb_aes256_encrypt_iter.sv
module tb_aes256_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] pt, rkey, ct;
  logic [3:0]   ridx;
  logic         busy, done;

  always #5 clk = ~clk;

  aes256_encrypt_iter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .plaintext_i  (pt),
    .round_idx_o  (ridx),
    .round_key_i  (rkey),
    .busy_o       (busy),
    .done_o       (done),
    .ciphertext_o (ct)
  );

  int vectors = 0;
  int errs    = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] rk_cur [15];

  // Combinational key table.
  assign rkey = (ridx < 4'd15) ? rk_cur[ridx] : 128'h0;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;
  exp_t sbq[$];

  // Reference model state (transaction level, counted in clock edges).
  int           ecnt = 0;
  bit           active = 1'b0;
  int           acc_edge = 0;
  logic [127:0] act_ct = '0;
  logic [127:0] last_ct = '0;
  bit           use_known = 1'b0;
  logic [127:0] known_ct = '0;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Z_CT   = 128'hdc95c078a2408989ad48a21492842087;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF inverse followed by the affine map.
  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[x] = s;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic void expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_cur[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = p[127-8*k -: 8] ^ rk_cur[0][127-8*k -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_m[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 14)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(8'h02, t[r]) ^ gmul(8'h03, t[(r+1)%4]) ^ t[(r+2)%4] ^ t[(r+3)%4];
        end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_cur[rnd][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s edge=%0d got=%h exp=%h", nm, ecnt - 1, got, exp);
    end
  endtask

  // Reference model: evaluates the inputs sampled at each rising edge.
  initial begin
    forever begin
      bit was_active;
      @(posedge clk);
      was_active = active;
      if (rst) begin
        active  = 1'b0;
        last_ct = '0;
        sbq.delete();
      end else begin
        if (active && ecnt == acc_edge + 14) begin
          last_ct = act_ct;
          active  = 1'b0;
        end
        if (start && !was_active) begin
          active   = 1'b1;
          acc_edge = ecnt;
          act_ct   = use_known ? known_ct : model_enc(pt);
          sbq.push_back('{ct: act_ct, due: ecnt + 14});
        end
      end
      ecnt++;
    end
  end

  // Monitor: per-cycle status plus scoreboard pop on every DONE.
  initial begin
    forever begin
      int   le;
      exp_t e;
      @(negedge clk);
      le = ecnt - 1;
      if (ecnt > 0) begin
        chk("busy", {127'h0, busy}, {127'h0, active});
        chk("round_idx", {124'h0, ridx}, active ? 128'(le - acc_edge + 1) : 128'h0);
        chk("ciphertext_hold", ct, last_ct);
        if (done || (sbq.size() > 0 && sbq[0].due == le)) begin
          vectors++;
          if (sbq.size() == 0) begin
            errs++;
            $display("FAIL done_unexpected edge=%0d got done=%0b exp done=0", le, done);
          end else begin
            e = sbq.pop_front();
            if (!done || e.due != le || ct !== e.ct) begin
              errs++;
              $display("FAIL done_ct edge=%0d got done=%0b ct=%h exp due=%0d ct=%h", le, done, ct, e.due, e.ct);
            end
          end
        end
      end
    end
  end

  task automatic pulse(input logic [127:0] p);
    start = 1'b1;
    pt    = p;
    @(negedge clk);
    start = 1'b0;
    pt    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n = 0;
    while (active && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (active) begin
      errs++;
      $display("FAIL wait_idle timeout got busy=1 exp busy=0");
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pt    = '0;
    build_sbox();
    expand(C3_KEY);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // FIPS-197 C.3 with two stray START pulses during RUN.
    use_known = 1'b1;
    known_ct  = C3_CT;
    pulse(C3_PT);
    repeat (2) @(negedge clk);
    pulse({$urandom, $urandom, $urandom, $urandom});
    repeat (5) @(negedge clk);
    pulse({$urandom, $urandom, $urandom, $urandom});
    wait_idle();

    // All-zero key and plaintext.
    expand('0);
    known_ct = Z_CT;
    pulse('0);
    wait_idle();
    use_known = 1'b0;

    // START held: back-to-back blocks, plaintext changing every cycle.
    expand(C3_KEY);
    start = 1'b1;
    for (int i = 0; i < 31; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Reset while round 7 is in flight, then a normal block.
    pulse({$urandom, $urandom, $urandom, $urandom});
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse({$urandom, $urandom, $urandom, $urandom});
    wait_idle();

    // Random keys, plaintexts and stray START pulses.
    for (int b = 0; b < 6; b++) begin
      expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      pulse({$urandom, $urandom, $urandom, $urandom});
      for (int j = 0; j < 13; j++) begin
        start = ($urandom_range(0, 3) == 0);
        pt    = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
      end
      start = 1'b0;
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    chk("scoreboard_drained", 128'(sbq.size()), 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
